// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction fetch unit. Holds the architectural PC, issues one
//             request at a time to instruction memory over a req/ack
//             handshake, and presents the fetched instruction and its PC to
//             decode. Redirects from decode/execute select the next PC when
//             the current instruction retires.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             imem_req/imem_addr  - registered memory request and address
//             imem_ack/imem_rdata - same-cycle accept with instruction data
//             stall               - downstream not ready to retire
//             jump_en/jump_target - redirect for the current instruction
//             instr/PC_now        - registered instruction and its PC
//             instr_valid         - instr/PC_now hold a fetched instruction
//             instret             - retired-instruction counter (wraps)
//             misalign_err        - sticky flag for a misaligned redirect
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATAWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [DATAWIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [DATAWIDTH-1:0] imem_rdata,
    input  logic                 stall,
    input  logic                 jump_en,
    input  logic [DATAWIDTH-1:0] jump_target,
    output logic [DATAWIDTH-1:0] instr,
    output logic [DATAWIDTH-1:0] PC_now,
    output logic                 instr_valid,
    output logic [31:0]          instret,
    output logic                 misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_pc;

    // The fetch address is the PC register itself, so it is already registered.
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            imem_req     <= 1'b0;
            instr        <= NOP_INSTR;
            PC_now       <= RESET_PC;
            instr_valid  <= 1'b0;
            instret      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_REQ;
                    imem_req <= 1'b1;
                end

                S_REQ: begin
                    // Request and address stay stable until memory accepts.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        PC_now      <= r_pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        r_state     <= S_VALID;
                    end
                end

                S_VALID: begin
                    if (!stall) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        imem_req    <= 1'b1;
                        r_state     <= S_REQ;
                        if (jump_en) begin
                            // Fetch continues from the word-aligned target even
                            // when the redirect is misaligned; the error is sticky.
                            r_pc <= {jump_target[DATAWIDTH-1:2], 2'b00};
                            if (jump_target[1:0] != 2'b00) begin
                                misalign_err <= 1'b1;
                            end
                        end else begin
                            r_pc <= r_pc + DATAWIDTH'(4);
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch
//  Purpose  : Self-checking bench for ifu_fetch. Two instances (default reset
//             PC and a reset PC at the top of the address space) share random
//             stimulus and are compared every cycle against a behavioural
//             model of the fetch/retire protocol.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ifu_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC0_A  = 32'h0000_0000;
    localparam logic [31:0] PC0_B  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;

    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] instr_a, instr_b;
    logic [31:0] pcn_a, pcn_b;
    logic        valid_a, valid_b;
    logic [31:0] iret_a, iret_b;
    logic        mis_a, mis_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifu_fetch dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req_a),
        .imem_addr   (addr_a),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .instr       (instr_a),
        .PC_now      (pcn_a),
        .instr_valid (valid_a),
        .instret     (iret_a),
        .misalign_err(mis_a)
    );

    ifu_fetch #(.RESET_PC(PC0_B)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req_b),
        .imem_addr   (addr_b),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .instr       (instr_b),
        .PC_now      (pcn_b),
        .instr_valid (valid_b),
        .instret     (iret_b),
        .misalign_err(mis_b)
    );

    // Behavioural view of the fetch unit: it is either in its one-cycle
    // start-up gap after reset, waiting on memory, or holding an instruction.
    typedef struct {
        bit          startup;
        bit          holding;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_now;
        logic [31:0] instret;
        bit          mis;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t next_model(input mdl_t m, input logic rstn,
                                        input logic ack, input logic stl,
                                        input logic jen, input logic [31:0] jt,
                                        input logic [31:0] rdata,
                                        input logic [31:0] pc0);
        mdl_t n = m;
        if (!rstn) begin
            n.startup = 1'b1;
            n.holding = 1'b0;
            n.pc      = pc0;
            n.instr   = NOP;
            n.pc_now  = pc0;
            n.instret = 32'd0;
            n.mis     = 1'b0;
        end else if (m.startup) begin
            n.startup = 1'b0;
        end else if (!m.holding) begin
            if (ack) begin
                n.holding = 1'b1;
                n.instr   = rdata;
                n.pc_now  = m.pc;
            end
        end else if (!stl) begin
            n.holding = 1'b0;
            n.instr   = NOP;
            n.instret = m.instret + 1;
            if (jen) begin
                n.pc = jt & ~32'h3;
                if ((jt % 4) != 0) n.mis = 1'b1;
            end else begin
                n.pc = m.pc + 4;
            end
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string who, input mdl_t m,
                             input logic req, input logic [31:0] addr,
                             input logic [31:0] ins, input logic [31:0] pcn,
                             input logic vld, input logic [31:0] iret,
                             input logic mis);
        logic exp_req;
        // A request is outstanding exactly while waiting on memory.
        exp_req = !m.startup && !m.holding;
        check_eq({who, ".imem_req"},     {31'd0, req}, {31'd0, exp_req});
        check_eq({who, ".imem_addr"},    addr,         m.pc);
        check_eq({who, ".instr"},        ins,          m.instr);
        check_eq({who, ".PC_now"},       pcn,          m.pc_now);
        check_eq({who, ".instr_valid"},  {31'd0, vld}, {31'd0, m.holding});
        check_eq({who, ".instret"},      iret,         m.instret);
        check_eq({who, ".misalign_err"}, {31'd0, mis}, {31'd0, m.mis});
    endtask

    task automatic step();
        @(posedge clk);
        m_a = next_model(m_a, rst_n, imem_ack, stall, jump_en, jump_target, imem_rdata, PC0_A);
        m_b = next_model(m_b, rst_n, imem_ack, stall, jump_en, jump_target, imem_rdata, PC0_B);
        #1;
        check_all("a", m_a, req_a, addr_a, instr_a, pcn_a, valid_a, iret_a, mis_a);
        check_all("b", m_b, req_b, addr_b, instr_b, pcn_b, valid_b, iret_b, mis_b);
    endtask

    initial begin
        logic [31:0] r;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        jump_en     = 1'b0;
        jump_target = 32'h0;
        repeat (2) step();

        // Sequential fetch with immediate ack and no stall.
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        repeat (8) step();

        // Randomized traffic, including occasional mid-handshake resets and
        // misaligned redirects.
        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            imem_ack   = ($urandom_range(0, 9) < 6);
            imem_rdata = $urandom;
            stall      = ($urandom_range(0, 9) < 4);
            jump_en    = ($urandom_range(0, 9) < 3);
            r          = $urandom;
            if ($urandom_range(0, 3) == 0)
                jump_target = (r & ~32'h3) | 32'($urandom_range(1, 3));
            else
                jump_target = r & ~32'h3;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
